// File: rtl/morse_tx_encoder.sv
// -----------------------------------------------------------------------------
// morse_tx_encoder
// Accepts one display-encoded symbol per valid/ready handshake and keys the
// corresponding ITU Morse pattern on key_out with unit-based timing.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   sym_in     symbol code (0x00-0x09 digits, 0x0A-0x23 A-Z, 0x3F word space)
//   sym_valid  source has a symbol
//   sym_ready  block can accept (IDLE only)
//   key_out    Morse key, 1 = mark
//   busy       high in every state except IDLE
//   done       one-cycle pulse when a symbol or word space completes
//   err        one-cycle pulse when an unsupported code is accepted
// -----------------------------------------------------------------------------
module morse_tx_encoder #(
   parameter int unsigned UNIT_CYCLES = 5000000,
   parameter int unsigned CNT_W       = 23
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] sym_in,
   input  logic       sym_valid,
   output logic       sym_ready,
   output logic       key_out,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [5:0]       WORD_CODE = 6'h3F;
   localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MARK,
      S_ELEM_GAP,
      S_CHAR_GAP,
      S_WORD_GAP
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_unit_cnt;
   logic [2:0]       r_units;
   logic [4:0]       r_pat;
   logic [2:0]       r_left;
   logic             r_key;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic             r_ready;

   logic [2:0]       w_rom_len;
   logic [4:0]       w_rom_pat;
   logic [2:0]       w_units_max;
   logic             w_unit_end;
   logic             w_state_end;

   // Pattern ROM: length 0 marks an unsupported code; bits left-aligned, 1 = dash
   always_comb begin
      {w_rom_len, w_rom_pat} = {3'd0, 5'b00000};
      case (sym_in)
         6'h00: {w_rom_len, w_rom_pat} = {3'd5, 5'b11111};
         6'h01: {w_rom_len, w_rom_pat} = {3'd5, 5'b01111};
         6'h02: {w_rom_len, w_rom_pat} = {3'd5, 5'b00111};
         6'h03: {w_rom_len, w_rom_pat} = {3'd5, 5'b00011};
         6'h04: {w_rom_len, w_rom_pat} = {3'd5, 5'b00001};
         6'h05: {w_rom_len, w_rom_pat} = {3'd5, 5'b00000};
         6'h06: {w_rom_len, w_rom_pat} = {3'd5, 5'b10000};
         6'h07: {w_rom_len, w_rom_pat} = {3'd5, 5'b11000};
         6'h08: {w_rom_len, w_rom_pat} = {3'd5, 5'b11100};
         6'h09: {w_rom_len, w_rom_pat} = {3'd5, 5'b11110};
         6'h0A: {w_rom_len, w_rom_pat} = {3'd2, 5'b01000}; // A
         6'h0B: {w_rom_len, w_rom_pat} = {3'd4, 5'b10000}; // B
         6'h0C: {w_rom_len, w_rom_pat} = {3'd4, 5'b10100}; // C
         6'h0D: {w_rom_len, w_rom_pat} = {3'd3, 5'b10000}; // D
         6'h0E: {w_rom_len, w_rom_pat} = {3'd1, 5'b00000}; // E
         6'h0F: {w_rom_len, w_rom_pat} = {3'd4, 5'b00100}; // F
         6'h10: {w_rom_len, w_rom_pat} = {3'd3, 5'b11000}; // G
         6'h11: {w_rom_len, w_rom_pat} = {3'd4, 5'b00000}; // H
         6'h12: {w_rom_len, w_rom_pat} = {3'd2, 5'b00000}; // I
         6'h13: {w_rom_len, w_rom_pat} = {3'd4, 5'b01110}; // J
         6'h14: {w_rom_len, w_rom_pat} = {3'd3, 5'b10100}; // K
         6'h15: {w_rom_len, w_rom_pat} = {3'd4, 5'b01000}; // L
         6'h16: {w_rom_len, w_rom_pat} = {3'd2, 5'b11000}; // M
         6'h17: {w_rom_len, w_rom_pat} = {3'd2, 5'b10000}; // N
         6'h18: {w_rom_len, w_rom_pat} = {3'd3, 5'b11100}; // O
         6'h19: {w_rom_len, w_rom_pat} = {3'd4, 5'b01100}; // P
         6'h1A: {w_rom_len, w_rom_pat} = {3'd4, 5'b11010}; // Q
         6'h1B: {w_rom_len, w_rom_pat} = {3'd3, 5'b01000}; // R
         6'h1C: {w_rom_len, w_rom_pat} = {3'd3, 5'b00000}; // S
         6'h1D: {w_rom_len, w_rom_pat} = {3'd1, 5'b10000}; // T
         6'h1E: {w_rom_len, w_rom_pat} = {3'd3, 5'b00100}; // U
         6'h1F: {w_rom_len, w_rom_pat} = {3'd4, 5'b00010}; // V
         6'h20: {w_rom_len, w_rom_pat} = {3'd3, 5'b01100}; // W
         6'h21: {w_rom_len, w_rom_pat} = {3'd4, 5'b10010}; // X
         6'h22: {w_rom_len, w_rom_pat} = {3'd4, 5'b10110}; // Y
         6'h23: {w_rom_len, w_rom_pat} = {3'd4, 5'b11000}; // Z
         default: {w_rom_len, w_rom_pat} = {3'd0, 5'b00000};
      endcase
   end

   // Last unit index of the current state; the current element is r_pat[4]
   always_comb begin
      w_units_max = 3'd0;
      case (r_state)
         S_MARK:     w_units_max = r_pat[4] ? 3'd2 : 3'd0;
         S_ELEM_GAP: w_units_max = 3'd0;
         S_CHAR_GAP: w_units_max = 3'd2;
         S_WORD_GAP: w_units_max = 3'd6;
         default:    w_units_max = 3'd0;
      endcase
   end

   // With UNIT_CYCLES=1 the counter stays at 0 and every cycle ends a unit
   assign w_unit_end  = (r_unit_cnt == UNIT_LAST);
   assign w_state_end = w_unit_end && (r_units == w_units_max);

   // Main FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_unit_cnt <= '0;
         r_units    <= 3'd0;
         r_pat      <= 5'b00000;
         r_left     <= 3'd0;
         r_key      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;

         // Timebase runs in every timed state; a state change restarts it
         if (r_state != S_IDLE) begin
            if (w_state_end) begin
               r_unit_cnt <= '0;
               r_units    <= 3'd0;
            end else if (w_unit_end) begin
               r_unit_cnt <= '0;
               r_units    <= r_units + 3'd1;
            end else begin
               r_unit_cnt <= r_unit_cnt + CNT_W'(1);
            end
         end

         case (r_state)
            S_IDLE: begin
               if (sym_valid) begin
                  if (sym_in == WORD_CODE) begin
                     r_state <= S_WORD_GAP;
                     r_busy  <= 1'b1;
                     r_ready <= 1'b0;
                  end else if (w_rom_len != 3'd0) begin
                     r_state <= S_MARK;
                     r_pat   <= w_rom_pat;
                     r_left  <= w_rom_len - 3'd1;
                     r_key   <= 1'b1;
                     r_busy  <= 1'b1;
                     r_ready <= 1'b0;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end

            S_MARK: begin
               if (w_state_end) begin
                  r_key <= 1'b0;
                  if (r_left != 3'd0) begin
                     r_state <= S_ELEM_GAP;
                     r_pat   <= {r_pat[3:0], 1'b0};
                     r_left  <= r_left - 3'd1;
                  end else begin
                     r_state <= S_CHAR_GAP;
                  end
               end
            end

            S_ELEM_GAP: begin
               if (w_state_end) begin
                  r_state <= S_MARK;
                  r_key   <= 1'b1;
               end
            end

            S_CHAR_GAP, S_WORD_GAP: begin
               if (w_state_end) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
                  r_done  <= 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_key   <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign sym_ready = r_ready;
   assign key_out   = r_key;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_morse_tx_encoder.sv
// -----------------------------------------------------------------------------
// tb_morse_tx_encoder
// Table-driven check of morse_tx_encoder: one instance at UNIT_CYCLES=4 and
// one at UNIT_CYCLES=1, plus hand-written invalid-code, hold-valid and
// mid-symbol reset sequences.
// -----------------------------------------------------------------------------
module tb_morse_tx_encoder;

   logic       clk;
   logic       rst;
   logic [5:0] sym_in0, sym_in1;
   logic       valid0, valid1;
   logic [1:0] ready_v, key_v, busy_v, done_v, err_v;

   int n_checks;
   int n_fail;

   typedef struct {
      int         sel;
      logic [5:0] code;
      int         plen;     // 0 = word space
      logic [4:0] pbits;    // left-aligned, 1 = dash
      int         exp_done; // cycle of done pulse, accept edge ends cycle 0
   } vec_t;

   vec_t vecs[10];

   morse_tx_encoder #(.UNIT_CYCLES(4), .CNT_W(2)) u_dut4 (
      .clk(clk), .rst(rst), .sym_in(sym_in0), .sym_valid(valid0),
      .sym_ready(ready_v[0]), .key_out(key_v[0]), .busy(busy_v[0]),
      .done(done_v[0]), .err(err_v[0])
   );

   morse_tx_encoder #(.UNIT_CYCLES(1), .CNT_W(1)) u_dut1 (
      .clk(clk), .rst(rst), .sym_in(sym_in1), .sym_valid(valid1),
      .sym_ready(ready_v[1]), .key_out(key_v[1]), .busy(busy_v[1]),
      .done(done_v[1]), .err(err_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drive one symbol (called #1 after a posedge), follow it to done, and
   // compare the keying waveform against a unit-timing model of the pattern.
   task automatic run_sym(input int sel, input logic [5:0] code, input int plen,
                          input logic [4:0] pbits, input int exp_done, input string name);
      logic [255:0] exp_key, got_key;
      int unit, pos, c, done_at, busy_cnt;
      logic rdy_at_done;
      unit = (sel == 0) ? 4 : 1;
      exp_key = '0;
      got_key = '0;
      pos = 1;
      if (plen == 0) begin
         pos += 7 * unit;
      end else begin
         for (int e = 0; e < plen; e++) begin
            for (int k = 0; k < (pbits[4-e] ? 3 : 1) * unit; k++) begin
               exp_key[pos] = 1'b1;
               pos++;
            end
            if (e < plen - 1) pos += unit;
         end
         pos += 3 * unit;
      end

      if (sel == 0) begin sym_in0 = code; valid0 = 1'b1; end
      else          begin sym_in1 = code; valid1 = 1'b1; end
      next_cycle();
      if (sel == 0) valid0 = 1'b0; else valid1 = 1'b0;

      c = 1; done_at = 0; busy_cnt = 0; rdy_at_done = 1'b0;
      while (done_at == 0 && c <= exp_done + 8) begin
         got_key[c] = key_v[sel];
         if (busy_v[sel]) busy_cnt++;
         if (done_v[sel]) begin
            done_at = c;
            rdy_at_done = ready_v[sel];
         end else begin
            next_cycle();
            c++;
         end
      end
      chk({name, "_done_cycle"}, done_at, exp_done);
      chk({name, "_model_len"}, pos, exp_done);
      chk_vec({name, "_key_wave"}, got_key, exp_key);
      chk({name, "_busy_cycles"}, busy_cnt, exp_done - 1);
      chk({name, "_ready_at_done"}, rdy_at_done, 1);
   endtask

   initial begin
      int done_seen, c, done_at;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      sym_in0 = 6'h00; sym_in1 = 6'h00;
      valid0 = 1'b0;   valid1 = 1'b0;

      vecs[0] = '{0, 6'h0E, 1, 5'b00000, 17}; // E
      vecs[1] = '{0, 6'h0A, 2, 5'b01000, 33}; // A
      vecs[2] = '{0, 6'h1A, 4, 5'b11010, 65}; // Q
      vecs[3] = '{0, 6'h05, 5, 5'b00000, 49}; // 5
      vecs[4] = '{0, 6'h14, 3, 5'b10100, 49}; // K
      vecs[5] = '{0, 6'h3F, 0, 5'b00000, 29}; // word space
      vecs[6] = '{1, 6'h00, 5, 5'b11111, 23}; // 0
      vecs[7] = '{1, 6'h3F, 0, 5'b00000, 8};  // word space back-to-back
      vecs[8] = '{1, 6'h23, 4, 5'b11000, 15}; // Z
      vecs[9] = '{1, 6'h1D, 1, 5'b10000, 7};  // T

      // Reset state
      #12;
      chk("rst_key", key_v, 2'b00);
      chk("rst_busy", busy_v, 2'b00);
      chk("rst_done", done_v, 2'b00);
      chk("rst_err", err_v, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      next_cycle();
      chk("post_rst_ready", ready_v, 2'b11);

      // Table: each vector launches immediately, so consecutive ones are back-to-back
      for (int i = 0; i < 10; i++)
         run_sym(vecs[i].sel, vecs[i].code, vecs[i].plen, vecs[i].pbits,
                 vecs[i].exp_done, $sformatf("v%0d", i));

      // Unsupported code: err pulse only
      next_cycle();
      sym_in0 = 6'h30; valid0 = 1'b1;
      next_cycle();
      valid0 = 1'b0;
      chk("inv_err_c1", err_v[0], 1);
      chk("inv_ready_c1", ready_v[0], 1);
      chk("inv_key_c1", key_v[0], 0);
      chk("inv_busy_c1", busy_v[0], 0);
      done_seen = 0;
      next_cycle();
      chk("inv_err_c2", err_v[0], 0);
      for (int k = 0; k < 10; k++) begin
         if (done_v[0] || key_v[0]) done_seen++;
         next_cycle();
      end
      chk("inv_no_done_no_key", done_seen, 0);

      // sym_valid held high across a busy symbol: next accept only at done
      sym_in0 = 6'h0E; valid0 = 1'b1;
      next_cycle();
      sym_in0 = 6'h1D;
      c = 1; done_at = 0;
      while (done_at == 0 && c <= 30) begin
         if (done_v[0]) done_at = c;
         else begin next_cycle(); c++; end
      end
      chk("hold_first_done", done_at, 17);
      next_cycle();
      valid0 = 1'b0;
      chk("hold_second_key", key_v[0], 1);
      chk("hold_second_busy", busy_v[0], 1);
      c = 18; done_at = 0;
      while (done_at == 0 && c <= 60) begin
         if (done_v[0]) done_at = c;
         else begin next_cycle(); c++; end
      end
      chk("hold_second_done", done_at, 42);

      // Reset in the middle of Q's first dash
      next_cycle();
      sym_in0 = 6'h1A; valid0 = 1'b1;
      next_cycle();
      valid0 = 1'b0;
      repeat (5) next_cycle();
      chk("midrst_key_before", key_v[0], 1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_key_async", key_v[0], 0);
      chk("midrst_busy_async", busy_v[0], 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      next_cycle();
      chk("midrst_ready_after", ready_v[0], 1);
      done_seen = 0;
      for (int k = 0; k < 8; k++) begin
         if (done_v[0] || key_v[0] || busy_v[0]) done_seen++;
         next_cycle();
      end
      chk("midrst_quiet", done_seen, 0);
      run_sym(0, 6'h1D, 1, 5'b10000, 25, "T_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
